fixed_memory_arbiter: RTL and testbench
=======================================

FIXED_MEMORY_ARBITER -- requirements
Module: fixed_memory_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, memory word width.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, memory address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port async_rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port clk_en  input  1  global enable; gates all state updates and handshakes.
REQ-006 SHALL have port sync_rst  input  1  synchronous active-high reset, same effect as async_rst.
REQ-007 SHALL have port ReqValid  input  2  request valid, bit i = requester i.
REQ-008 SHALL have port ReqReady  output  2  request accepted this cycle.
REQ-009 SHALL have port ReqWrite  input  2  1 = write, 0 = read.
REQ-010 SHALL have port ReqAddr  input  2*ADDRWIDTH  requester i at [i*ADDRWIDTH +: ADDRWIDTH].
REQ-011 SHALL have port ReqData  input  2*DATAWIDTH  write data, packed as ReqAddr.
REQ-012 SHALL have port RespValid  output  2  read response valid to requester i.
REQ-013 SHALL have port RespReady  input  2  requester i accepts response.
REQ-014 SHALL have port RespData  output  DATAWIDTH  shared read data.
REQ-015 SHALL have ports MemEn/MemWrite output 1, MemAddr output ADDRWIDTH, MemWrData output DATAWIDTH  single-port memory command.
REQ-016 SHALL have port MemRdData  input  DATAWIDTH  memory read data, valid the cycle after a read command; memory shares clk_en so data holds while clk_en low.

Function
REQ-017 SHALL implement states IDLE, READ_WAIT, RESP_HOLD; plus registers LastGrant (1b), Owner (1b), HoldData (DATAWIDTH).
REQ-018 IDLE, clk_en=1, any ReqValid: SHALL grant g = the sole valid requester, or on tie the requester != LastGrant; ReqReady[g]=1 combinationally, other bit 0.
REQ-019 On grant SHALL drive MemEn=1, MemWrite=ReqWrite[g], MemAddr/MemWrData = requester g fields, same cycle; LastGrant<=g.
REQ-020 Write grant SHALL stay in IDLE; back-to-back writes sustain one per cycle, alternating on contention.
REQ-021 Read grant SHALL set Owner<=g and go to READ_WAIT.
REQ-022 READ_WAIT: ReqReady=0, MemEn=0; RespValid[Owner]=1, RespData=MemRdData; RespReady[Owner]=1 -> IDLE, else HoldData<=MemRdData -> RESP_HOLD.
REQ-023 RESP_HOLD: RespValid[Owner]=1, RespData=HoldData; RespReady[Owner]=1 -> IDLE; remain otherwise indefinitely.
REQ-024 Read latency: response visible cycle N+1 after acceptance at N; minimum read interval 2 cycles.
REQ-025 RespReady on the non-Owner bit SHALL be ignored; RespValid non-Owner bit SHALL be 0.
REQ-026 When not granting (no valid, non-IDLE, or clk_en=0), MemEn, MemWrite, MemAddr, MemWrData SHALL be 0.
REQ-027 clk_en=0: ReqReady=0, RespValid=0, MemEn=0, all registers hold.
REQ-028 RespData SHALL be 0 in IDLE.

Reset
REQ-029 async_rst=1 SHALL immediately force IDLE, LastGrant=1, Owner=0, HoldData=0.
REQ-030 sync_rst=1 at a rising edge SHALL apply the same values regardless of clk_en.
REQ-031 After reset, outputs: ReqReady=0 (until a valid arrives), RespValid=0, RespData=0, all Mem* = 0.
REQ-032 Reset during READ_WAIT or RESP_HOLD SHALL drop the pending response; no RespValid follows.
REQ-033 First tie after reset SHALL grant requester 0.

Verification
REQ-034 Both requesters write every cycle (0: addr 1 data 0xAAAA; 1: addr 2 data 0xBBBB) -> grants alternate 0,1,0,1, MemEn=1 every cycle.
REQ-035 Requester 0 reads addr 5 holding 0x1234, RespReady=1 -> RespValid[0]=1, RespData=0x1234 next cycle, IDLE cycle after.
REQ-036 Requester 1 read, RespReady low 3 cycles -> RESP_HOLD, RespData steady at captured value, ReqReady=0 throughout; completes on RespReady=1.
REQ-037 clk_en low during READ_WAIT for 2 cycles -> RespValid=0, state held; response delivered unchanged when clk_en returns.
REQ-038 async_rst pulse in RESP_HOLD -> RespValid=0 immediately, IDLE, next tie grants requester 0.

Source files
------------

// File: rtl/fixed_memory_arbiter_if.sv
// Request/response/memory bundle for the two-requester memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface fixed_memory_arbiter_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 10
);
  logic [1:0]             ReqValid;
  logic [1:0]             ReqReady;
  logic [1:0]             ReqWrite;
  logic [2*ADDRWIDTH-1:0] ReqAddr;
  logic [2*DATAWIDTH-1:0] ReqData;
  logic [1:0]             RespValid;
  logic [1:0]             RespReady;
  logic [DATAWIDTH-1:0]   RespData;
  logic                   MemEn;
  logic                   MemWrite;
  logic [ADDRWIDTH-1:0]   MemAddr;
  logic [DATAWIDTH-1:0]   MemWrData;
  logic [DATAWIDTH-1:0]   MemRdData;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, RespReady, MemRdData,
    output ReqReady, RespValid, RespData, MemEn, MemWrite, MemAddr, MemWrData
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData, RespReady, MemRdData,
    input  ReqReady, RespValid, RespData, MemEn, MemWrite, MemAddr, MemWrData
  );
endinterface

// File: rtl/fixed_memory_arbiter.sv
// Two-requester arbiter in front of a single-port memory: alternating priority on
// contention, one write per cycle, reads held until the owning requester accepts.
module fixed_memory_arbiter #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  fixed_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, RESP_HOLD} state_t;

  state_t               state_reg;
  logic                 last_grant_reg;
  logic                 owner_reg;
  logic [DATAWIDTH-1:0] hold_data_reg;

  logic [ADDRWIDTH-1:0] req_addr [0:1];
  logic [DATAWIDTH-1:0] req_data [0:1];
  logic                 grant_valid;
  logic                 grant_idx;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_addr[gi] = bus.ReqAddr[gi*ADDRWIDTH +: ADDRWIDTH];
      assign req_data[gi] = bus.ReqData[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  // On a tie the requester that did not win last time gets the slot.
  assign grant_valid = clk_en && (state_reg == IDLE) && (|bus.ReqValid);
  assign grant_idx   = (bus.ReqValid == 2'b11) ? ~last_grant_reg : bus.ReqValid[1];

  always_comb begin
    bus.ReqReady  = 2'b00;
    bus.MemEn     = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWrData = '0;
    if (grant_valid) begin
      bus.ReqReady  = grant_idx ? 2'b10 : 2'b01;
      bus.MemEn     = 1'b1;
      bus.MemWrite  = bus.ReqWrite[grant_idx];
      bus.MemAddr   = req_addr[grant_idx];
      bus.MemWrData = req_data[grant_idx];
    end
  end

  always_comb begin
    bus.RespValid = 2'b00;
    if (clk_en && (state_reg != IDLE))
      bus.RespValid = owner_reg ? 2'b10 : 2'b01;
  end

  // Read data comes straight from memory the first cycle, then from the capture register.
  always_comb begin
    case (state_reg)
      READ_WAIT: bus.RespData = bus.MemRdData;
      RESP_HOLD: bus.RespData = hold_data_reg;
      default:   bus.RespData = '0;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      hold_data_reg  <= '0;
    end else if (sync_rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      hold_data_reg  <= '0;
    end else if (clk_en) begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            last_grant_reg <= grant_idx;
            if (!bus.ReqWrite[grant_idx]) begin
              owner_reg <= grant_idx;
              state_reg <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (bus.RespReady[owner_reg]) begin
            state_reg <= IDLE;
          end else begin
            hold_data_reg <= bus.MemRdData;
            state_reg     <= RESP_HOLD;
          end
        end
        RESP_HOLD: begin
          if (bus.RespReady[owner_reg])
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_memory_arbiter.sv
// Directed bench for fixed_memory_arbiter with a behavioural single-port memory
// whose read port returns 0xDEAD on any cycle that did not follow a read command.
module tb_fixed_memory_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic async_rst;
  logic clk_en;
  logic sync_rst;

  int n_vec = 0;
  int n_err = 0;

  fixed_memory_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  fixed_memory_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .sync_rst  (sync_rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_data = 16'hDEAD;

  assign bus.MemRdData = rd_data;

  always @(posedge clk) begin
    if (clk_en) begin
      if (bus.MemEn && bus.MemWrite)
        mem[bus.MemAddr] <= bus.MemWrData;
      rd_data <= (bus.MemEn && !bus.MemWrite) ? mem[bus.MemAddr] : 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.ReqValid = v;
    bus.ReqWrite = w;
    bus.ReqAddr  = {a1, a0};
    bus.ReqData  = {d1, d0};
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[5] = 16'h1234;
    mem[9] = 16'h5678;

    async_rst = 1'b1;
    sync_rst  = 1'b0;
    clk_en    = 1'b1;
    bus.RespReady = 2'b00;
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #2;
    chk("rst_reqready",  bus.ReqReady,  2'b00);
    chk("rst_respvalid", bus.RespValid, 2'b00);
    chk("rst_respdata",  bus.RespData,  16'h0);
    chk("rst_memen",     bus.MemEn,     1'b0);
    chk("rst_memaddr",   bus.MemAddr,   10'h0);
    tick();
    async_rst = 1'b0;
    tick();

    // Contending writers alternate, first tie goes to requester 0
    set_req(2'b11, 2'b11, 10'd1, 16'hAAAA, 10'd2, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_reqready", bus.ReqReady, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("wr_memen",    bus.MemEn,    1'b1);
      chk("wr_memwrite", bus.MemWrite, 1'b1);
      chk("wr_memaddr",  bus.MemAddr,  (i % 2 == 0) ? 10'd1 : 10'd2);
      chk("wr_memdata",  bus.MemWrData,(i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
      tick();
    end

    // Requester 0 reads addr 5 with RespReady high
    set_req(2'b01, 2'b00, 10'd5, 16'h0, 10'd0, 16'h0);
    bus.RespReady = 2'b01;
    #1;
    chk("rd0_reqready",  bus.ReqReady,  2'b01);
    chk("rd0_memwrite",  bus.MemWrite,  1'b0);
    chk("rd0_memaddr",   bus.MemAddr,   10'd5);
    chk("rd0_respvalid", bus.RespValid, 2'b00);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    chk("rd0_resp_valid", bus.RespValid, 2'b01);
    chk("rd0_resp_data",  bus.RespData,  16'h1234);
    chk("rd0_wait_memen", bus.MemEn,     1'b0);
    tick();
    #1;
    chk("rd0_idle_valid", bus.RespValid, 2'b00);
    chk("rd0_idle_data",  bus.RespData,  16'h0);

    // Requester 1 reads addr 9, RespReady low 3 cycles; non-owner ready ignored
    set_req(2'b10, 2'b00, 10'd0, 16'h0, 10'd9, 16'h0);
    bus.RespReady = 2'b00;
    #1;
    chk("rd1_reqready", bus.ReqReady, 2'b10);
    chk("rd1_memaddr",  bus.MemAddr,  10'd9);
    tick();
    set_req(2'b01, 2'b01, 10'd7, 16'h7777, 10'd0, 16'h0);
    bus.RespReady = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd1_hold_valid", bus.RespValid, 2'b10);
      chk("rd1_hold_data",  bus.RespData,  16'h5678);
      chk("rd1_hold_ready", bus.ReqReady,  2'b00);
      chk("rd1_hold_memen", bus.MemEn,     1'b0);
      tick();
    end
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    bus.RespReady = 2'b10;
    #1;
    chk("rd1_done_valid", bus.RespValid, 2'b10);
    chk("rd1_done_data",  bus.RespData,  16'h5678);
    tick();
    #1;
    chk("rd1_idle_valid", bus.RespValid, 2'b00);

    // clk_en low in IDLE blocks grants and memory commands
    clk_en = 1'b0;
    set_req(2'b11, 2'b00, 10'd3, 16'h1111, 10'd4, 16'h2222);
    #1;
    chk("cen_idle_ready", bus.ReqReady, 2'b00);
    chk("cen_idle_memen", bus.MemEn,    1'b0);
    chk("cen_idle_addr",  bus.MemAddr,  10'd0);
    tick();

    // clk_en low for 2 cycles during READ_WAIT
    clk_en = 1'b1;
    set_req(2'b01, 2'b00, 10'd5, 16'h0, 10'd0, 16'h0);
    bus.RespReady = 2'b01;
    #1;
    chk("cen_grant", bus.ReqReady, 2'b01);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("cen_off_valid", bus.RespValid, 2'b00);
      chk("cen_off_ready", bus.ReqReady,  2'b00);
      tick();
    end
    clk_en = 1'b1;
    #1;
    chk("cen_on_valid", bus.RespValid, 2'b01);
    chk("cen_on_data",  bus.RespData,  16'h1234);
    tick();
    #1;
    chk("cen_idle_valid", bus.RespValid, 2'b00);

    // async_rst pulse in RESP_HOLD; addr 2 was written by requester 1 above
    set_req(2'b01, 2'b00, 10'd2, 16'h0, 10'd0, 16'h0);
    bus.RespReady = 2'b00;
    #1;
    chk("ar_grant", bus.ReqReady, 2'b01);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    chk("ar_wait_data", bus.RespData, 16'hBBBB);
    tick();
    #1;
    chk("ar_hold_valid", bus.RespValid, 2'b01);
    chk("ar_hold_data",  bus.RespData,  16'hBBBB);
    async_rst = 1'b1;
    #1;
    chk("ar_rst_valid", bus.RespValid, 2'b00);
    chk("ar_rst_data",  bus.RespData,  16'h0);
    #1;
    async_rst = 1'b0;
    tick();
    set_req(2'b11, 2'b11, 10'd1, 16'hAAAA, 10'd2, 16'hBBBB);
    #1;
    chk("ar_tie_ready", bus.ReqReady,  2'b01);
    chk("ar_tie_valid", bus.RespValid, 2'b00);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    chk("ar_after_valid", bus.RespValid, 2'b00);
    tick();

    // sync_rst during READ_WAIT with clk_en low
    set_req(2'b01, 2'b00, 10'd5, 16'h0, 10'd0, 16'h0);
    #1;
    chk("sr_grant", bus.ReqReady, 2'b01);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    clk_en   = 1'b0;
    sync_rst = 1'b1;
    #1;
    chk("sr_off_valid", bus.RespValid, 2'b00);
    tick();
    sync_rst = 1'b0;
    clk_en   = 1'b1;
    set_req(2'b11, 2'b11, 10'd1, 16'hAAAA, 10'd2, 16'hBBBB);
    #1;
    chk("sr_valid",     bus.RespValid, 2'b00);
    chk("sr_tie_ready", bus.ReqReady,  2'b01);
    tick();
    set_req(2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    chk("sr_after_valid", bus.RespValid, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
